hoist_ctrl: RTL and testbench

- Hoist/elevator control FSM that responds to the go_up / go_down / halt command interface.
- Tracks cabin position with a bounded counter and raises the top and bottom limit flags.
- Exposes current and next state, one-hot, for cross-checking of behavioural vs synthesized netlists.
- Sits between the command source and the motor/limit-indication logic.

---
 rtl/hoist_ctrl_if.sv | 30 +++
 rtl/hoist_ctrl.sv | 122 ++++++++++++
 tb/tb_hoist_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hoist_ctrl_if.sv
// Command and status bundle between a hoist command source and hoist_ctrl.
//   go_up, go_down, halt : level-sensitive travel / stop requests (source -> hoist)
//   estado               : registered current state, one-hot (hoist -> source)
//   prox_estado          : combinational next state, one-hot (hoist -> source)
//   pos                  : registered cabin position (hoist -> source)
//   top_lim, bott_lim    : registered limit flags, coincident with pos
//   fault                : sticky conflicting-command flag
interface hoist_ctrl_if #(
   parameter int POS_W = 3
);
   logic             go_up;
   logic             go_down;
   logic             halt;
   logic [4:0]       estado;
   logic [4:0]       prox_estado;
   logic [POS_W-1:0] pos;
   logic             top_lim;
   logic             bott_lim;
   logic             fault;

   modport master (
      output go_up, go_down, halt,
      input  estado, prox_estado, pos, top_lim, bott_lim, fault
   );

   modport slave (
      input  go_up, go_down, halt,
      output estado, prox_estado, pos, top_lim, bott_lim, fault
   );
endinterface

// File: rtl/hoist_ctrl.sv
// Hoist control FSM with a saturating cabin position counter.
// Ports:
//   CLK   : system clock, rising edge active
//   RESET : asynchronous active-high reset, parks the cabin at the bottom
//   bus   : hoist_ctrl_if slave side (commands in, state/position/limits/fault out)
// The one-hot current and next state are both exported so behavioural and
// synthesized netlists can be cross-checked cycle by cycle.
module hoist_ctrl #(
   parameter int TOP_POS = 5,
   parameter int POS_W   = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   hoist_ctrl_if.slave bus
);
   typedef enum logic [4:0] {
      REPOSO   = 5'h01,
      SUBIENDO = 5'h02,
      BAJANDO  = 5'h04,
      TOPE     = 5'h08,
      FONDO    = 5'h10
   } state_t;

   localparam logic [POS_W-1:0] POS_TOP    = POS_W'(TOP_POS);
   localparam logic [POS_W-1:0] POS_TOP_M1 = POS_W'(TOP_POS - 1);
   localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
   localparam logic [POS_W-1:0] POS_ZERO   = '0;

   state_t           state_q;
   state_t           state_d;
   state_t           park;
   logic [POS_W-1:0] pos_q;
   logic [POS_W-1:0] pos_d;
   logic             top_q;
   logic             bott_q;
   logic             fault_q;
   logic             conflict;
   logic             cmd_stop;

   assign conflict = bus.go_up & bus.go_down;
   assign cmd_stop = bus.halt | conflict;

   // Where the cabin rests when it stops: the label depends only on the
   // position seen now, even if the counter still takes one more step.
   always_comb begin
      park = REPOSO;
      if (pos_q == POS_TOP) begin
         park = TOPE;
      end else if (pos_q == POS_ZERO) begin
         park = FONDO;
      end
   end

   // Next-state decision. A stop beats everything; an unknown (non one-hot)
   // state also falls back to the park state so an upset self-recovers.
   // Reversal goes straight from one travel state to the other.
   always_comb begin
      state_d = state_q;
      if (cmd_stop) begin
         state_d = park;
      end else begin
         case (state_q)
            FONDO:    state_d = bus.go_up ? SUBIENDO : FONDO;
            TOPE:     state_d = bus.go_down ? BAJANDO : TOPE;
            REPOSO: begin
               if (bus.go_up)        state_d = SUBIENDO;
               else if (bus.go_down) state_d = BAJANDO;
               else                  state_d = REPOSO;
            end
            SUBIENDO: begin
               if (bus.go_up)        state_d = (pos_q == POS_TOP_M1) ? TOPE : SUBIENDO;
               else if (bus.go_down) state_d = BAJANDO;
               else                  state_d = REPOSO;
            end
            BAJANDO: begin
               if (bus.go_down)      state_d = (pos_q == POS_ONE) ? FONDO : BAJANDO;
               else if (bus.go_up)   state_d = SUBIENDO;
               else                  state_d = REPOSO;
            end
            default:  state_d = park;
         endcase
      end
   end

   // Position moves according to the state already registered, which gives
   // the one-edge lag between entering a travel state and the first step.
   always_comb begin
      pos_d = pos_q;
      if (state_q == SUBIENDO && pos_q < POS_TOP) begin
         pos_d = pos_q + POS_ONE;
      end else if (state_q == BAJANDO && pos_q != POS_ZERO) begin
         pos_d = pos_q - POS_ONE;
      end
   end

   // State, position and limit registers. Limits are computed from the
   // incoming position so they line up with pos on the same edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= FONDO;
         pos_q   <= POS_ZERO;
         top_q   <= 1'b0;
         bott_q  <= 1'b1;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         top_q   <= (pos_d == POS_TOP);
         bott_q  <= (pos_d == POS_ZERO);
         if (conflict && !bus.halt) begin
            fault_q <= 1'b1;
         end
      end
   end

   assign bus.estado      = state_q;
   assign bus.prox_estado = state_d;
   assign bus.pos         = pos_q;
   assign bus.top_lim     = top_q;
   assign bus.bott_lim    = bott_q;
   assign bus.fault       = fault_q;
endmodule

// File: tb/tb_hoist_ctrl.sv
// Self-checking bench for hoist_ctrl: a directed vector table, a hand-written
// asynchronous reset sequence, and randomized commands against a reference model.
module tb_hoist_ctrl;
   localparam int TOP_POS = 5;
   localparam int POS_W   = 3;
   localparam int NVEC    = 30;

   // Model modes
   localparam int M_BOTTOM = 0;
   localparam int M_MID    = 1;
   localparam int M_TOP    = 2;
   localparam int M_UP     = 3;
   localparam int M_DOWN   = 4;

   logic CLK = 1'b0;
   logic RESET;

   hoist_ctrl_if #(.POS_W(POS_W)) bus ();

   hoist_ctrl #(.TOP_POS(TOP_POS), .POS_W(POS_W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       up;
      logic       dn;
      logic       h;
      logic [4:0] st;
      int         p;
      logic       top;
      logic       bot;
      logic       flt;
   } vec_t;

   vec_t vecs [NVEC];

   int m_mode;
   int m_pos;
   int m_fault;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic up, input logic dn, input logic h);
      bus.go_up   = up;
      bus.go_down = dn;
      bus.halt    = h;
      #1;
   endtask

   task automatic stepClock();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   function automatic logic [31:0] modeCode(input int m);
      case (m)
         M_BOTTOM: return 32'h10;
         M_MID:    return 32'h01;
         M_TOP:    return 32'h08;
         M_UP:     return 32'h02;
         default:  return 32'h04;
      endcase
   endfunction

   function automatic int parkMode(input int p);
      if (p == TOP_POS) return M_TOP;
      if (p == 0)       return M_BOTTOM;
      return M_MID;
   endfunction

   function automatic int modelNext(input int m, input int p, input logic up, input logic dn, input logic h);
      if (h || (up && dn)) return parkMode(p);
      case (m)
         M_BOTTOM: return up ? M_UP : M_BOTTOM;
         M_TOP:    return dn ? M_DOWN : M_TOP;
         M_MID:    return up ? M_UP : (dn ? M_DOWN : M_MID);
         M_UP: begin
            if (up) return (p == TOP_POS - 1) ? M_TOP : M_UP;
            if (dn) return M_DOWN;
            return M_MID;
         end
         default: begin
            if (dn) return (p == 1) ? M_BOTTOM : M_DOWN;
            if (up) return M_UP;
            return M_MID;
         end
      endcase
   endfunction

   task automatic modelReset();
      m_mode  = M_BOTTOM;
      m_pos   = 0;
      m_fault = 0;
   endtask

   task automatic checkAgainstModel(input string tag);
      checkOutput({tag, " estado"},   32'(bus.estado),   modeCode(m_mode));
      checkOutput({tag, " pos"},      32'(bus.pos),      32'(m_pos));
      checkOutput({tag, " top_lim"},  32'(bus.top_lim),  32'(m_pos == TOP_POS));
      checkOutput({tag, " bott_lim"}, 32'(bus.bott_lim), 32'(m_pos == 0));
      checkOutput({tag, " fault"},    32'(bus.fault),    32'(m_fault));
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " estado"},      32'(bus.estado),      32'h10);
      checkOutput({tag, " prox_estado"}, 32'(bus.prox_estado), 32'h10);
      checkOutput({tag, " pos"},         32'(bus.pos),         32'h0);
      checkOutput({tag, " top_lim"},     32'(bus.top_lim),     32'h0);
      checkOutput({tag, " bott_lim"},    32'(bus.bott_lim),    32'h1);
      checkOutput({tag, " fault"},       32'(bus.fault),       32'h0);
   endtask

   initial begin
      // Directed path: ascent, top hold, reversals, bottom, halt, conflict
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'h02, 0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'h02, 1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'h02, 2, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'h02, 3, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 5'h02, 4, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'h08, 5, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'h08, 5, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'h04, 5, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'h04, 4, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'h04, 3, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 5'h02, 2, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 5'h02, 3, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 5'h04, 4, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 5'h04, 3, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 5'h04, 2, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 5'h04, 1, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 5'h10, 0, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 5'h10, 0, 1'b0, 1'b1, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 5'h02, 0, 1'b0, 1'b1, 1'b0};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 5'h02, 1, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{1'b1, 1'b0, 1'b0, 5'h02, 2, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{1'b1, 1'b0, 1'b1, 5'h01, 3, 1'b0, 1'b0, 1'b0};
      vecs[22] = '{1'b1, 1'b0, 1'b1, 5'h01, 3, 1'b0, 1'b0, 1'b0};
      vecs[23] = '{1'b1, 1'b0, 1'b0, 5'h02, 3, 1'b0, 1'b0, 1'b0};
      vecs[24] = '{1'b1, 1'b0, 1'b0, 5'h02, 4, 1'b0, 1'b0, 1'b0};
      vecs[25] = '{1'b0, 1'b0, 1'b1, 5'h01, 5, 1'b1, 1'b0, 1'b0};
      vecs[26] = '{1'b1, 1'b0, 1'b0, 5'h02, 5, 1'b1, 1'b0, 1'b0};
      vecs[27] = '{1'b0, 1'b0, 1'b0, 5'h01, 5, 1'b1, 1'b0, 1'b0};
      vecs[28] = '{1'b1, 1'b1, 1'b0, 5'h08, 5, 1'b1, 1'b0, 1'b1};
      vecs[29] = '{1'b0, 1'b0, 1'b0, 5'h08, 5, 1'b1, 1'b0, 1'b1};

      // Reset held over two edges
      RESET = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checkResetValues("reset");
      RESET = 1'b0;

      // Directed vector table
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].up, vecs[i].dn, vecs[i].h);
         stepClock();
         checkOutput($sformatf("vec%0d estado", i),   32'(bus.estado),   32'(vecs[i].st));
         checkOutput($sformatf("vec%0d pos", i),      32'(bus.pos),      32'(vecs[i].p));
         checkOutput($sformatf("vec%0d top_lim", i),  32'(bus.top_lim),  32'(vecs[i].top));
         checkOutput($sformatf("vec%0d bott_lim", i), 32'(bus.bott_lim), 32'(vecs[i].bot));
         checkOutput($sformatf("vec%0d fault", i),    32'(bus.fault),    32'(vecs[i].flt));
      end

      // Descent from the top with fault set, then reset between edges
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         stepClock();
      end
      checkOutput("descent estado", 32'(bus.estado), 32'h04);
      checkOutput("descent pos",    32'(bus.pos),    32'd3);
      #2;
      RESET = 1'b1;
      #1;
      checkResetValues("async_reset");
      bus.go_down = 1'b0;
      stepClock();
      RESET = 1'b0;

      // Randomized commands against the reference model
      modelReset();
      for (int i = 0; i < 800; i++) begin
         int   r;
         int   nxt;
         logic up;
         logic dn;
         logic h;
         if (i % 200 == 199) begin
            RESET = 1'b1;
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkResetValues("rand_reset");
            stepClock();
            RESET = 1'b0;
            modelReset();
         end
         r  = int'($urandom_range(0, 7));
         up = (r <= 2) || (r == 7);
         dn = (r >= 3 && r <= 5) || (r == 7);
         h  = ($urandom_range(0, 11) == 0);
         applyStimulus(up, dn, h);
         nxt = modelNext(m_mode, m_pos, up, dn, h);
         checkOutput("rand prox_estado", 32'(bus.prox_estado), modeCode(nxt));
         if (m_mode == M_UP && m_pos < TOP_POS) m_pos = m_pos + 1;
         else if (m_mode == M_DOWN && m_pos > 0) m_pos = m_pos - 1;
         if (up && dn && !h) m_fault = 1;
         m_mode = nxt;
         stepClock();
         checkAgainstModel("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
